// File: rtl/display7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display driver.
// Segment vectors are active-low, bit6 = a ... bit0 = g.
package display7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t GLYPH_0 = 7'h01;
  localparam seg_t GLYPH_1 = 7'h4F;
  localparam seg_t GLYPH_2 = 7'h12;
  localparam seg_t GLYPH_3 = 7'h06;
  localparam seg_t GLYPH_4 = 7'h4C;
  localparam seg_t GLYPH_5 = 7'h24;
  localparam seg_t GLYPH_6 = 7'h20;
  localparam seg_t GLYPH_7 = 7'h0F;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h0C;
  localparam seg_t GLYPH_A = 7'h08;
  localparam seg_t GLYPH_B = 7'h60;
  localparam seg_t GLYPH_C = 7'h31;
  localparam seg_t GLYPH_D = 7'h42;
  localparam seg_t GLYPH_E = 7'h30;
  localparam seg_t GLYPH_F = 7'h38;

  // Nibbles 10-15 only have a glyph in hex mode; in decimal mode they go dark.
  function automatic seg_t glyph(input logic [3:0] nibble, input logic hex_mode);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = hex_mode ? GLYPH_A : SEG_BLANK;
      4'hB:    seg = hex_mode ? GLYPH_B : SEG_BLANK;
      4'hC:    seg = hex_mode ? GLYPH_C : SEG_BLANK;
      4'hD:    seg = hex_mode ? GLYPH_D : SEG_BLANK;
      4'hE:    seg = hex_mode ? GLYPH_E : SEG_BLANK;
      default: seg = hex_mode ? GLYPH_F : SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display7_glyph.sv
// Combinational nibble-to-segment decoder; one instance sits on the scanned nibble.
module display7_glyph
  import display7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg_t       segments
);

  assign segments = glyph(nibble, hex_mode);

endmodule

// File: rtl/display7_scan_mux.sv
// Scanned driver for N common-anode 7-segment digits with dead time and frame-aligned value swap.
// Optional `define LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module display7_scan_mux
  import display7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output seg_t                  segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pending;
  logic [4*N_DIGITS-1:0] active;
  logic [N_DIGITS-1:0]   pending_dp;
  logic [N_DIGITS-1:0]   active_dp;
  logic                  pending_valid;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  in_dead;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic [N_DIGITS-1:0]   anode_sel;
  logic                  blank;
  seg_t                  glyph_seg;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);
  assign in_dead    = (slot_cnt < DEAD_END);

  // Scan position: slot counter inside a digit, digit index across the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Double-buffered value: loads land in pending, the frame wrap promotes them.
  // A load on the wrap cycle stays pending; the swap takes the old pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      active        <= '0;
      active_dp     <= '0;
    end else begin
      if (frame_wrap && pending_valid) begin
        active    <= pending;
        active_dp <= pending_dp;
      end
      if (load) begin
        pending       <= data;
        pending_dp    <= dp_mask;
        pending_valid <= 1'b1;
      end else if (frame_wrap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cur_nibble = '0;
    cur_dp     = 1'b0;
    anode_sel  = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble   = active[4*i +: 4];
        cur_dp       = active_dp[i];
        anode_sel[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Blank when this digit and every digit above it are zero, unless it carries a dp.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (active[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = (idx != '0) && !cur_dp && upper_zero;
  end
`else
  assign blank = 1'b0;
`endif

  display7_glyph u_glyph (
    .nibble   (cur_nibble),
    .hex_mode (hex_mode),
    .segments (glyph_seg)
  );

  // Registered pin drivers; glyphs follow the scan position by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments   <= SEG_BLANK;
      dp         <= 1'b1;
      anodes     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (in_dead) begin
        segments <= SEG_BLANK;
        dp       <= 1'b1;
        anodes   <= '1;
      end else if (blank) begin
        segments <= SEG_BLANK;
        dp       <= 1'b1;
        anodes   <= anode_sel;
      end else begin
        segments <= glyph_seg;
        dp       <= ~cur_dp;
        anodes   <= anode_sel;
      end
    end
  end

endmodule

// File: tb/tb_display7_scan_mux.sv
// Self-checking bench for display7_scan_mux (N_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2).
// Cycle-by-cycle reference model plus table-driven per-frame digit checks.
module tb_display7_scan_mux;

  localparam int N = 4;
  localparam int S = 8;
  localparam int D = 2;
  localparam int F = N * S;

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        hex_mode;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anodes;
  logic        frame_done;

  display7_scan_mux #(
    .N_DIGITS    (N),
    .SCAN_DIV    (S),
    .DEAD_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .load       (load),
    .hex_mode   (hex_mode),
    .dp_mask    (dp_mask),
    .segments   (segments),
    .dp         (dp),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since reset release, and the two value buffers.
  int          m_k;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  bit          m_pv, m_frame;

  logic [3:0][6:0] seen_seg;
  logic [3:0]      seen_dp;
  int              cnt_4f, cnt_12;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dpm;
    bit              hex;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int v, input bit hx);
    if (v >= 10 && !hx) return 7'h7F;
    return GLYPH_REF[v];
  endfunction

  // One clock: drive inputs, predict outputs from the pre-edge model, compare after the edge.
  task automatic cycle(input bit r, input bit ld, input logic [15:0] d,
                       input logic [3:0] dm, input bit hx);
    logic [12:0] exp_v;
    int slot, dig, nib;
    bit lz;
    rst = r; load = ld; data = d; dp_mask = dm; hex_mode = hx;
    @(posedge clk);
    if (r) begin
      exp_v = {1'b0, 1'b1, 4'hF, 7'h7F};
      m_k = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_pv = 0; m_frame = 0;
    end else begin
      slot    = m_k % S;
      dig     = (m_k / S) % N;
      nib     = int'((m_act >> (4 * dig)) & 16'hF);
      m_frame = ((m_k + 1) % F) == 0;
      lz      = 0;
`ifdef LEADING_ZERO_BLANK_EN
      lz = (dig != 0) && !m_adp[dig] && ((m_act >> (4 * dig)) == 16'h0);
`endif
      if (slot < D)
        exp_v = {m_frame, 1'b1, 4'hF, 7'h7F};
      else if (lz)
        exp_v = {m_frame, 1'b1, 4'hF & ~(4'b1 << dig), 7'h7F};
      else
        exp_v = {m_frame, ~m_adp[dig], 4'hF & ~(4'b1 << dig), ref_glyph(nib, hx)};
      if (m_frame) begin
        if (m_pv) begin m_act = m_pend; m_adp = m_pdp; end
        m_pv = 0;
      end
      if (ld) begin m_pend = d; m_pdp = dm; m_pv = 1; end
      m_k++;
    end
    #1;
    check("outputs", {19'd0, frame_done, dp, anodes, segments}, {19'd0, exp_v});
    for (int i = 0; i < N; i++) begin
      if (anodes[i] === 1'b0) begin
        seen_seg[i] = segments;
        seen_dp[i]  = dp;
      end
    end
    if (anodes !== 4'hF && segments === 7'h4F) cnt_4f++;
    if (anodes !== 4'hF && segments === 7'h12) cnt_12++;
  endtask

  task automatic idle(input int n, input bit hx);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, hx);
  endtask

  task automatic wait_frame(input string name, input bit hx);
    int guard = 0;
    while (frame_done !== 1'b1 && guard < 3 * F) begin
      cycle(0, 0, '0, '0, hx);
      guard++;
    end
    check(name, 32'(guard < 3 * F), 32'd1);
  endtask

  task automatic run_vector(input int vi);
    int guard = 0;
    cycle(0, 1, vecs[vi].data, vecs[vi].dpm, vecs[vi].hex);
    while (!(frame_done === 1'b1 && !m_pv) && guard < 3 * F) begin
      cycle(0, 0, '0, '0, vecs[vi].hex);
      guard++;
    end
    check($sformatf("vec%0d_swap", vi), 32'(guard < 3 * F), 32'd1);
    seen_seg = 'x;
    seen_dp  = 'x;
    idle(F, vecs[vi].hex);
    for (int i = 0; i < N; i++) begin
      check($sformatf("vec%0d_seg_digit%0d", vi, i), 32'(seen_seg[i]), 32'(vecs[vi].seg[i]));
      check($sformatf("vec%0d_dp_digit%0d", vi, i), 32'(seen_dp[i]), 32'(vecs[vi].dpo[i]));
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111};
    vecs[1] = '{16'hA5C9, 4'b0010, 1'b0, {7'h7F, 7'h24, 7'h7F, 7'h0C}, 4'b1101};
    vecs[2] = '{16'h8F60, 4'b0000, 1'b1, {7'h00, 7'h38, 7'h20, 7'h01}, 4'b1111};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'h0070, 4'b0000, 1'b0, {7'h7F, 7'h7F, 7'h0F, 7'h01}, 4'b1111};
    vecs[4] = '{16'h0070, 4'b0100, 1'b0, {7'h7F, 7'h01, 7'h0F, 7'h01}, 4'b1011};
`else
    vecs[3] = '{16'h0070, 4'b0000, 1'b0, {7'h01, 7'h01, 7'h0F, 7'h01}, 4'b1111};
    vecs[4] = '{16'h0070, 4'b0100, 1'b0, {7'h01, 7'h01, 7'h0F, 7'h01}, 4'b1011};
`endif
    vecs[5] = '{16'hBEEF, 4'b0000, 1'b1, {7'h60, 7'h30, 7'h30, 7'h38}, 4'b1111};

    // Reset held 3 cycles, then the first lit anode appears 3 cycles after release.
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, 0);
    idle(2, 0);
    check("dead_gap_anodes", 32'(anodes), 32'hF);
    idle(1, 0);
    check("first_anode", 32'(anodes), 32'hE);

    for (int v = 0; v < 6; v++) run_vector(v);

    // hex_mode dropped mid-frame: BEEF goes dark from the next registered glyph.
    idle(12, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, '0, '0, 0);
      if (anodes !== 4'hF) check("hex_off_glyph", 32'(segments), 32'h7F);
    end

    // Two loads within one frame: only the later one is ever displayed.
    wait_frame("frame_wait_a", 0);
    cycle(0, 1, 16'h1111, 4'h0, 0);
    idle(5, 0);
    cycle(0, 1, 16'h2222, 4'h0, 0);
    cnt_4f = 0;
    cnt_12 = 0;
    idle(3 * F, 0);
    check("last_load_wins_no_1", 32'(cnt_4f), 32'd0);
    check("last_load_wins_shows_2", 32'(cnt_12 > 0), 32'd1);

    // Load on the swap cycle stays pending for one extra frame.
    while (((m_k + 1) % F) != 0) cycle(0, 0, '0, '0, 0);
    cycle(0, 1, 16'h3333, 4'h0, 0);
    check("swap_cycle_frame_done", 32'(frame_done), 32'd1);
    seen_seg = 'x;
    idle(F, 0);
    check("swap_load_old_d0", 32'(seen_seg[0]), 32'h12);
    check("swap_load_old_d3", 32'(seen_seg[3]), 32'h12);
    seen_seg = 'x;
    idle(F, 0);
    check("swap_load_new_d0", 32'(seen_seg[0]), 32'h06);
    check("swap_load_new_d3", 32'(seen_seg[3]), 32'h06);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(0, ($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom), 1'($urandom));
    end

    // Reset mid-slot with a pending load: everything returns to reset, old value gone.
    wait_frame("frame_wait_b", 0);
    cycle(0, 1, 16'h5555, 4'hF, 0);
    idle(S + 3, 0);
    cycle(1, 0, '0, '0, 0);
    check("midscan_rst_anodes", 32'(anodes), 32'hF);
    check("midscan_rst_segments", 32'(segments), 32'h7F);
    seen_seg = 'x;
    idle(2 * F, 0);
    check("post_rst_digit0", 32'(seen_seg[0]), 32'h01);
`ifdef LEADING_ZERO_BLANK_EN
    check("post_rst_digit2", 32'(seen_seg[2]), 32'h7F);
`else
    check("post_rst_digit2", 32'(seen_seg[2]), 32'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
